// File: rtl/uart_reg_master_if.sv
// uart_reg_master_if: request/response port of the UART register initiator.
//   req_valid/req_ready   valid/ready handshake for one register access
//   req_write/req_addr    access type (1 = write) and register index
//   req_wdata             write data
//   resp_valid            one-cycle completion pulse
//   resp_error/resp_rdata completion status and read data, qualified by resp_valid
//   master modport: the requester; slave modport: uart_reg_master
interface uart_reg_master_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [6:0]    req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_error;
  logic [DW-1:0] resp_rdata;
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata
  );
endinterface

// File: rtl/uart_reg_master.sv
// uart_reg_master: serializes register read/write requests into UART bytes and parses the replies.
//   clock                 sole clock, rising edge
//   srst                  asynchronous active-high reset
//   bus                   request/response port (uart_reg_master_if.slave)
//   uart_tx_value(_write) byte to send and its one-cycle load strobe
//   uart_tx_value_done    transmitter finished the current byte
//   uart_rx_value(_ready) received byte and its one-cycle qualifier
module uart_reg_master #(
  parameter int NUM_BYTES_PER_REG = 4,
  parameter int NUM_REGISTERS     = 8,
  parameter int TIMEOUT_CYCLES    = 1_000_000
) (
  input  logic             clock,
  input  logic             srst,
  uart_reg_master_if.slave bus,
  output logic [7:0]       uart_tx_value,
  output logic             uart_tx_value_write,
  input  logic             uart_tx_value_done,
  input  logic [7:0]       uart_rx_value,
  input  logic             uart_rx_value_ready
);
  localparam int DW = 8 * NUM_BYTES_PER_REG;
  localparam int CW = $clog2(NUM_BYTES_PER_REG + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WR_BYTES = CW'(NUM_BYTES_PER_REG);
  localparam logic [CW-1:0] LAST_RX  = CW'(NUM_BYTES_PER_REG - 1);
  // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, TX, TX_WAIT, RX, DONE} state_t;

  state_t        state;
  logic          write_q;
  logic [7:0]    cmd_q;
  logic [DW-1:0] tx_shift;
  logic [DW-1:0] rx_buf;
  logic [DW-1:0] rx_next;
  logic [CW-1:0] tx_left;
  logic [CW-1:0] rx_count;
  logic [TW-1:0] tmo_cnt;
  logic          in_range;

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign rx_next  = DW'({uart_rx_value, rx_buf} >> 8);
  assign in_range = int'(bus.req_addr) < NUM_REGISTERS;

  always_ff @(posedge clock or posedge srst)
    if (srst) begin
      state               <= IDLE;
      bus.req_ready       <= 1'b0;
      bus.resp_valid      <= 1'b0;
      bus.resp_error      <= 1'b0;
      bus.resp_rdata      <= '0;
      uart_tx_value       <= '0;
      uart_tx_value_write <= 1'b0;
      write_q             <= 1'b0;
      cmd_q               <= '0;
      tx_shift            <= '0;
      rx_buf              <= '0;
      tx_left             <= '0;
      rx_count            <= '0;
      tmo_cnt             <= '0;
    end else begin
      uart_tx_value_write <= 1'b0;
      bus.resp_valid      <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            write_q       <= bus.req_write;
            cmd_q         <= {bus.req_write, bus.req_addr};
            tx_shift      <= bus.req_wdata;
            tx_left       <= bus.req_write ? WR_BYTES : '0;
            rx_buf        <= '0;
            rx_count      <= '0;
            if (in_range) begin
              // Strobe is registered on entry so it is high throughout TX.
              state               <= TX;
              uart_tx_value       <= {bus.req_write, bus.req_addr};
              uart_tx_value_write <= 1'b1;
            end else begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        TX: state <= TX_WAIT;
        TX_WAIT:
          if (uart_tx_value_done) begin
            if (tx_left == '0) begin
              state   <= RX;
              tmo_cnt <= '0;
            end else begin
              state               <= TX;
              tx_left             <= tx_left - 1'b1;
              uart_tx_value       <= tx_shift[7:0];
              tx_shift            <= tx_shift >> 8;
              uart_tx_value_write <= 1'b1;
            end
          end
        RX:
          // A byte on the expiry edge wins over the timeout.
          if (uart_rx_value_ready) begin
            tmo_cnt  <= '0;
            rx_count <= rx_count + 1'b1;
            rx_buf   <= rx_next;
            if (write_q) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= uart_rx_value != cmd_q;
              bus.resp_rdata <= '0;
            end else if (rx_count == LAST_RX) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b0;
              bus.resp_rdata <= rx_next;
            end
          end else if (tmo_cnt == TMO_PRE) begin
            state          <= DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b1;
            bus.resp_rdata <= '0;
          end else
            tmo_cnt <= tmo_cnt + 1'b1;
        DONE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
